// File: rtl/instr_fetch_queue.sv
// Fetch queue: accepts PCs, issues 1-cycle-latency instruction memory reads and
// buffers returned {instr, pc, misaligned} entries in a DEPTH-entry FIFO for decode.
module instr_fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             pc_valid_i,
    output logic             pc_ready_o,
    input  logic             flush_i,
    output logic             mem_en_o,
    output logic [WIDTH-1:0] mem_addr_o,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] instr_pc_o,
    output logic             instr_misaligned_o,
    output logic             instr_valid_o,
    input  logic             instr_ready_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] fifo_instr_q [DEPTH];
    logic [WIDTH-1:0] fifo_pc_q    [DEPTH];
    logic             fifo_mis_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             inflight_valid_q, inflight_valid_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic             inflight_mis_q, inflight_mis_d;

    logic [PTR_W:0] occupancy;
    logic           accept;
    logic           push;
    logic           pop;

    // Credit counts the in-flight read so a returning instruction always has a slot;
    // same-cycle pops are deliberately ignored to keep instr_ready_i off pc_ready_o.
    always_comb begin
        occupancy          = count_q + {{PTR_W{1'b0}}, inflight_valid_q};
        pc_ready_o         = !rst && !flush_i && (occupancy < DEPTH_C);
        accept             = pc_valid_i && pc_ready_o;
        mem_en_o           = accept;
        mem_addr_o         = pc_i;
        instr_valid_o      = (count_q != '0);
        pop                = instr_valid_o && instr_ready_i;
        push               = inflight_valid_q && !flush_i && !rst;
        instr_o            = fifo_instr_q[rd_ptr_q];
        instr_pc_o         = fifo_pc_q[rd_ptr_q];
        instr_misaligned_o = fifo_mis_q[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        inflight_valid_d = accept;
        inflight_pc_d    = accept ? pc_i : inflight_pc_q;
        inflight_mis_d   = accept ? (|pc_i[1:0]) : inflight_mis_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A redirect drops the returning read and everything queued.
        if (flush_i) begin
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            count_d          = '0;
            inflight_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            inflight_valid_q <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            inflight_valid_q <= inflight_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        inflight_pc_q  <= inflight_pc_d;
        inflight_mis_q <= inflight_mis_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= mem_rdata_i;
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
            fifo_mis_q[wr_ptr_q]   <= inflight_mis_q;
        end
    end

endmodule
